// File: rtl/mem_arbiter.sv
// Purpose : shares one memory between instruction fetch and load/store.
//           Data has priority; a bounded starvation counter lets fetch through.
// Latency : grants are combinational; read data returns exactly one cycle after grant.
// Backpressure: requesters hold req until gnt; rvalid is a one-cycle pulse, no stall.
// Ports   : if_*  fetch requester (read only, word reads)
//           d_*   load/store requester (funct3 sized accesses)
//           mem_* shared memory read port, write port and funct3
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // shared memory
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       rd_pend_q;
  logic       rd_owner_q;   // 0 = fetch, 1 = data

  logic word_store;
  logic overlap;
  logic fetch_forced;
  logic d_win;
  logic i_win;
  logic load_gnt;
  logic store_gnt;

  // A word store only needs the write port, and fetch always reads with
  // funct3=010, so the two can share a cycle without a funct3 conflict.
  always_comb begin
    word_store   = d_req & d_we & (d_funct3 == F3_WORD);
    overlap      = word_store & if_req;
    fetch_forced = if_req & (starve_cnt == LIMIT);
    d_win        = overlap | (d_req & ~fetch_forced);
    i_win        = overlap | (if_req & (fetch_forced | ~d_req));
  end

  // Grants are gated by reset so nothing is consumed while rst_n is low.
  assign if_gnt    = rst_n & i_win;
  assign d_gnt     = rst_n & d_win;
  assign load_gnt  = d_gnt & ~d_we;
  assign store_gnt = d_gnt & d_we;

  // Memory drive. When idle, the memory performs a dummy word read of
  // address 0 whose result is never returned (rd_pend_q stays low).
  always_comb begin
    mem_write_mem     = store_gnt;
    mem_write_address = store_gnt ? d_addr  : 32'h0;
    mem_write_data    = store_gnt ? d_wdata : 32'h0;
    mem_funct3        = d_gnt ? d_funct3 : F3_WORD;
    if (load_gnt) begin
      mem_read_address = d_addr;
    end else if (if_gnt) begin
      mem_read_address = if_addr;
    end else begin
      mem_read_address = 32'h0;
    end
  end

  // Read tracking: a load and a fetch are never granted together, so one
  // owner bit is enough to steer the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= load_gnt | if_gnt;
      rd_owner_q <= load_gnt;
    end
  end

  // Counts consecutive data wins while fetch is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign if_rvalid = rd_pend_q & ~rd_owner_q;
  assign d_rvalid  = rd_pend_q &  rd_owner_q;
  assign if_rdata  = mem_read_data;
  assign d_rdata   = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-addressed memory with a synchronous read
// port stands in for the real memory; a shadow copy and a rule-level
// arbitration model give the expected grants, drives and returned data.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory stand-in ----------------
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [31:0] bd_data;
  logic [7:0]  mem [0:4095];

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lo,
                                         input logic [31:0] w);
    logic [31:0] s;
    s = w >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin : mem_model
    logic [11:0] ra;
    logic [11:0] wa;
    logic [31:0] rw;
    ra = mem_read_address[11:0];
    rw = {mem[{ra[11:2], 2'd3}], mem[{ra[11:2], 2'd2}],
          mem[{ra[11:2], 2'd1}], mem[{ra[11:2], 2'd0}]};
    mem_read_data <= extend(mem_funct3, ra[1:0], rw);
    wa = mem_write_address[11:0];
    if (mem_write_mem) begin
      case (mem_funct3[1:0])
        2'b00: mem[wa] <= mem_write_data[7:0];
        2'b01: begin
          mem[wa]                 <= mem_write_data[7:0];
          mem[{wa[11:1], 1'b1}]   <= mem_write_data[15:8];
        end
        default: begin
          mem[{wa[11:2], 2'd0}] <= mem_write_data[7:0];
          mem[{wa[11:2], 2'd1}] <= mem_write_data[15:8];
          mem[{wa[11:2], 2'd2}] <= mem_write_data[23:16];
          mem[{wa[11:2], 2'd3}] <= mem_write_data[31:24];
        end
      endcase
    end
    if (bd_we) begin
      mem[{bd_addr[11:2], 2'd0}] <= bd_data[7:0];
      mem[{bd_addr[11:2], 2'd1}] <= bd_data[15:8];
      mem[{bd_addr[11:2], 2'd2}] <= bd_data[23:16];
      mem[{bd_addr[11:2], 2'd3}] <= bd_data[31:24];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] shadow [0:4095];
  int         streak;      // consecutive data wins while fetch waits
  int         checks;
  int         errors;

  logic        obs_if_gnt, obs_d_gnt, obs_if_rvalid, obs_d_rvalid;
  logic [31:0] obs_if_rdata, obs_d_rdata;

  function automatic logic [31:0] ref_read(input logic [2:0] f3, input logic [31:0] addr);
    logic [11:0] a;
    logic [31:0] w;
    a = addr[11:0];
    w = {shadow[{a[11:2], 2'd3}], shadow[{a[11:2], 2'd2}],
         shadow[{a[11:2], 2'd1}], shadow[{a[11:2], 2'd0}]};
    return extend(f3, a[1:0], w);
  endfunction

  task automatic ref_write(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    logic [11:0] a;
    a = addr[11:0];
    if (f3[1:0] == 2'b00) begin
      shadow[a] = d[7:0];
    end else if (f3[1:0] == 2'b01) begin
      shadow[{a[11:1], 1'b0}] = d[7:0];
      shadow[{a[11:1], 1'b1}] = d[15:8];
    end else begin
      for (int k = 0; k < 4; k++) shadow[{a[11:2], 2'(k)}] = d[8*k +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
    if_req = 1'b0; d_req = 1'b0;
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    ref_write(3'b010, addr, data);
    @(posedge clk); #1;
    bd_we = 1'b0;
    streak = 0;
  endtask

  // One arbitration cycle: drive, check grants and memory drive against the
  // rules, then check what comes back after the edge.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [2:0] df, input logic [31:0] da, input logic [31:0] dd);
    logic eig, edg, erd, eown, ews;
    logic [31:0] edata;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_funct3 = df; d_addr = da; d_wdata = dd;
    #1;
    if (ir && dr && dw && df == 3'b010) begin
      eig = 1'b1; edg = 1'b1;                 // word store rides alongside fetch
    end else if (ir && streak >= LIMIT) begin
      eig = 1'b1; edg = 1'b0;
    end else begin
      edg = dr; eig = ir && !dr;
    end
    chk("if_gnt", 32'(if_gnt), 32'(eig));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    obs_if_gnt = if_gnt; obs_d_gnt = d_gnt;
    ews  = edg && dw;
    eown = edg && !dw;
    erd  = eown || eig;
    chk("mem_write_mem", 32'(mem_write_mem), 32'(ews));
    chk("mem_write_address", mem_write_address, ews ? da : 32'h0);
    chk("mem_write_data", mem_write_data, ews ? dd : 32'h0);
    chk("mem_read_address", mem_read_address, eown ? da : (eig ? ia : 32'h0));
    chk("mem_funct3", 32'(mem_funct3), 32'(edg ? df : 3'b010));
    edata = eown ? ref_read(df, da) : ref_read(3'b010, ia);
    if (ews) ref_write(df, da, dd);
    if (eig || !ir) streak = 0;
    else if (edg && streak < LIMIT) streak++;
    @(posedge clk); #1;
    obs_if_rvalid = if_rvalid; obs_d_rvalid = d_rvalid;
    obs_if_rdata = if_rdata; obs_d_rdata = d_rdata;
    chk("if_rvalid", 32'(if_rvalid), 32'(erd && !eown));
    chk("d_rvalid", 32'(d_rvalid), 32'(erd && eown));
    if (erd && eown)  chk("d_rdata", d_rdata, edata);
    if (erd && !eown) chk("if_rdata", if_rdata, edata);
  endtask

  logic        r_if_act, r_d_act, r_d_we;
  logic [2:0]  r_d_f3;
  logic [31:0] r_if_addr, r_d_addr, r_d_wdata, mask;
  int          k;

  initial begin
    checks = 0; errors = 0; streak = 0;
    for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
    rst_n = 1'b0; bd_we = 1'b0; bd_addr = 32'h0; bd_data = 32'h0;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h8; d_wdata = 32'h5A;

    // Reset: outputs quiet and grants suppressed even with requests present.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_d_gnt", 32'(d_gnt), 32'h0);
    chk("rst_mem_write_mem", 32'(mem_write_mem), 32'h0);
    chk("rst_starve_cnt", 32'(dut.starve_cnt), 32'h0);
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clear the whole memory region used, then preload.
    for (int a = 0; a < 1024; a += 4) bd_write(32'(a), 32'h0);
    bd_write(32'h0, 32'h00000013);

    // 1. fetch only
    step(1'b1, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("t1_if_gnt", 32'(obs_if_gnt), 32'h1);
    chk("t1_if_rvalid", 32'(obs_if_rvalid), 32'h1);
    chk("t1_if_rdata", obs_if_rdata, 32'h00000013);
    chk("t1_d_rvalid", 32'(obs_d_rvalid), 32'h0);

    // 2. fetch vs load contention: D,D,D,D,I repeating
    step(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'(4 * i), 32'h0);
      chk("t2_pattern", {30'h0, obs_if_gnt, obs_d_gnt}, (i % 5 == 4) ? 32'h2 : 32'h1);
      chk("t2_owner", {30'h0, obs_if_rvalid, obs_d_rvalid}, (i % 5 == 4) ? 32'h2 : 32'h1);
    end

    // 3. word store overlapping a fetch of the same word
    step(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    bd_write(32'h100, 32'h11111111);
    step(1'b1, 32'h100, 1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("t3_both_gnt", {30'h0, obs_if_gnt, obs_d_gnt}, 32'h3);
    chk("t3_old_word", obs_if_rdata, 32'h11111111);
    step(1'b1, 32'h100, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("t3_new_word", obs_if_rdata, 32'hDEADBEEF);

    // 4. byte store blocks the fetch for one cycle
    bd_write(32'h200, 32'h0);
    step(1'b1, 32'h0, 1'b1, 1'b1, 3'b000, 32'h202, 32'h000000AB);
    chk("t4_only_d", {30'h0, obs_if_gnt, obs_d_gnt}, 32'h1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("t4_if_next", 32'(obs_if_gnt), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    chk("t4_word", obs_d_rdata, 32'h00AB0000);

    // 5. signed / unsigned byte loads
    bd_write(32'h104, 32'h00008000);
    step(1'b0, 32'h0, 1'b1, 1'b0, 3'b000, 32'h105, 32'h0);
    chk("t5_lb", obs_d_rdata, 32'hFFFFFF80);
    step(1'b0, 32'h0, 1'b1, 1'b0, 3'b100, 32'h105, 32'h0);
    chk("t5_lbu", obs_d_rdata, 32'h00000080);

    // 6. reset in the cycle after a load grant
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h104;
    #1;
    chk("t6_d_gnt", 32'(d_gnt), 32'h1);
    @(posedge clk); #1;
    chk("t6_cnt_before", 32'(dut.starve_cnt), 32'h1);
    d_we = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("t6_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("t6_starve_cnt", 32'(dut.starve_cnt), 32'h0);
    chk("t6_gnt_forced", {30'h0, if_gnt, d_gnt}, 32'h0);
    chk("t6_wr_forced", 32'(mem_write_mem), 32'h0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    streak = 0;
    step(1'b1, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("t6_refetch", obs_if_rdata, 32'h00000013);

    // Randomized traffic honouring the hold-until-grant contract.
    r_if_act = 1'b0; r_d_act = 1'b0; r_d_we = 1'b0; r_d_f3 = 3'b010;
    r_if_addr = 32'h0; r_d_addr = 32'h0; r_d_wdata = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!r_if_act && $urandom_range(0, 3) != 0) begin
        r_if_act  = 1'b1;
        r_if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!r_d_act && $urandom_range(0, 3) != 0) begin
        r_d_act = 1'b1;
        r_d_we  = 1'($urandom_range(0, 1));
        k = int'($urandom_range(0, 4));
        if (r_d_we) begin
          r_d_f3 = 3'(k % 3);
        end else begin
          case (k)
            0: r_d_f3 = 3'b000;
            1: r_d_f3 = 3'b001;
            2: r_d_f3 = 3'b010;
            3: r_d_f3 = 3'b100;
            default: r_d_f3 = 3'b101;
          endcase
        end
        mask = (r_d_f3[1:0] == 2'b00) ? 32'hFFFFFFFF :
               (r_d_f3[1:0] == 2'b01) ? 32'hFFFFFFFE : 32'hFFFFFFFC;
        r_d_addr  = 32'($urandom_range(0, 1023)) & mask;
        r_d_wdata = $urandom;
      end
      step(r_if_act, r_if_addr, r_d_act, r_d_we, r_d_f3, r_d_addr, r_d_wdata);
      if (obs_if_gnt) r_if_act = 1'b0;
      if (obs_d_gnt)  r_d_act  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
